// File: rtl/seq_stage_ctrl_if.sv
// Sequencer-facing bundle: fetch/execute/memory results in, pc, stage enables and status out.
// Pure wiring, no latency.
// mem_req/mem_ready carry the data-memory handshake; everything else is level-valued.
interface seq_stage_ctrl_if;
  logic        start;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        hlt;
  logic [63:0] valP;
  logic [63:0] valC;
  logic [63:0] valM;
  logic        cnd;
  logic        mem_ready;
  logic        dmem_error;
  logic [63:0] pc;
  logic        fetch_en;
  logic        decode_en;
  logic        execute_en;
  logic        memory_en;
  logic        wb_en;
  logic        mem_req;
  logic [2:0]  stat;
  logic        halted;
  logic [31:0] instr_cnt;

  // sequencer side
  modport master (
    input  start, icode, instr_valid, imem_error, hlt, valP, valC, valM, cnd,
           mem_ready, dmem_error,
    output pc, fetch_en, decode_en, execute_en, memory_en, wb_en, mem_req, stat,
           halted, instr_cnt
  );

  // datapath / environment side
  modport slave (
    output start, icode, instr_valid, imem_error, hlt, valP, valC, valM, cnd,
           mem_ready, dmem_error,
    input  pc, fetch_en, decode_en, execute_en, memory_en, wb_en, mem_req, stat,
           halted, instr_cnt
  );
endinterface

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle SEQ Y86 sequencer: owns pc, steps FETCH..PCUPD with one-hot enables, stops on faults.
// Latency: 6 cycles per non-memory instruction, 5+k for memory ones (k = MEMORY cycles).
// Backpressure: MEMORY holds mem_req until mem_ready, faulting with ADR after MEM_TIMEOUT cycles.
module seq_stage_ctrl #(
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_stage_ctrl_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WB, S_PCUPD, S_HALTED
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    icode_q;
  logic [63:0]   valp_q, valc_q, valm_q;
  logic [63:0]   pc_q, pc_nxt;
  logic [2:0]    stat_q, fault_stat;
  logic [31:0]   cnt_q;
  logic [CW-1:0] mem_cnt;
  logic          is_mem, mem_timeout;
  logic          fetch_en, decode_en, execute_en, memory_en, wb_en, mem_req, halted;

  // icode is latched in DECODE, so these stay stable through MEMORY and PCUPD
  assign is_mem      = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign mem_timeout = (mem_cnt == CW'(MEM_TIMEOUT));

  // decode-time fault classification: ADR beats INS beats HLT
  always_comb begin
    fault_stat = STAT_AOK;
    if (bus.imem_error)        fault_stat = STAT_ADR;
    else if (!bus.instr_valid) fault_stat = STAT_INS;
    else if (bus.hlt)          fault_stat = STAT_HLT;
  end

  // next pc: call/taken jump -> valC, ret -> latched valM, otherwise fall through to valP
  always_comb begin
    pc_nxt = valp_q;
    case (icode_q)
      4'h7:    pc_nxt = bus.cnd ? valc_q : valp_q;
      4'h8:    pc_nxt = valc_q;
      4'h9:    pc_nxt = valm_q;
      default: pc_nxt = valp_q;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; memory ready wins over timeout in the final allowed cycle
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.start) state_nxt = S_FETCH;
      S_FETCH:   state_nxt = S_DECODE;
      S_DECODE:  state_nxt = (fault_stat != STAT_AOK) ? S_HALTED : S_EXECUTE;
      S_EXECUTE: state_nxt = S_MEMORY;
      S_MEMORY: begin
        if (!is_mem)            state_nxt = S_WB;
        else if (bus.mem_ready) state_nxt = bus.dmem_error ? S_HALTED : S_WB;
        else if (mem_timeout)   state_nxt = S_HALTED;
      end
      S_WB:      state_nxt = S_PCUPD;
      S_PCUPD:   state_nxt = S_FETCH;
      S_HALTED:  state_nxt = S_HALTED;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // stage enables and handshake outputs decoded from the current state
  always_comb begin
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    memory_en  = 1'b0;
    wb_en      = 1'b0;
    mem_req    = 1'b0;
    halted     = 1'b0;
    case (state)
      S_FETCH:   fetch_en   = 1'b1;
      S_DECODE:  decode_en  = 1'b1;
      S_EXECUTE: execute_en = 1'b1;
      S_MEMORY: begin
        memory_en = 1'b1;
        mem_req   = is_mem;
      end
      S_WB:      wb_en      = 1'b1;
      S_HALTED:  halted     = 1'b1;
      default:   ;
    endcase
  end

  // architectural state: pc, status, retire count, latched fetch/memory results, memory timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      stat_q  <= STAT_AOK;
      cnt_q   <= 32'd0;
      icode_q <= 4'h0;
      valp_q  <= 64'd0;
      valc_q  <= 64'd0;
      valm_q  <= 64'd0;
      mem_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) pc_q <= RESET_PC;
        S_DECODE: begin
          icode_q <= bus.icode;
          valp_q  <= bus.valP;
          valc_q  <= bus.valC;
          if (fault_stat != STAT_AOK) stat_q <= fault_stat;
        end
        S_EXECUTE: mem_cnt <= CW'(1);
        S_MEMORY: begin
          if (is_mem) begin
            if (bus.mem_ready) begin
              valm_q <= bus.valM;
              if (bus.dmem_error) stat_q <= STAT_ADR;
            end else if (mem_timeout) begin
              stat_q <= STAT_ADR;
            end else begin
              mem_cnt <= mem_cnt + CW'(1);
            end
          end
        end
        S_PCUPD: begin
          pc_q  <= pc_nxt;
          cnt_q <= cnt_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pc         = pc_q;
  assign bus.stat       = stat_q;
  assign bus.instr_cnt  = cnt_q;
  assign bus.fetch_en   = fetch_en;
  assign bus.decode_en  = decode_en;
  assign bus.execute_en = execute_en;
  assign bus.memory_en  = memory_en;
  assign bus.wb_en      = wb_en;
  assign bus.mem_req    = mem_req;
  assign bus.halted     = halted;
endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Self-checking bench for seq_stage_ctrl: per-instruction transaction model vs DUT.
// Each instruction is checked for latency, mem_req cycles, pc, stat, retire count, halt and enables.
// Memory readiness is scripted per instruction; randomized sequences cover mixed icodes and faults.
module tb_seq_stage_ctrl;
  localparam int T = 16;

  typedef struct {
    logic [3:0]  icode;
    logic [63:0] valp, valc, valm;
    bit          cnd, imem_err, ivalid, hlt, derr;
    int          ready_at;   // MEMORY cycle at which mem_ready rises; 0 = never
  } instr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  // reference model: architectural state seen between instructions
  logic [63:0] m_pc;
  logic [31:0] m_cnt;
  logic [2:0]  m_stat;
  bit          m_halt;

  seq_stage_ctrl_if bus ();
  seq_stage_ctrl #(.RESET_PC(64'd0), .MEM_TIMEOUT(T)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic instr_t mk(logic [3:0] ic, logic [63:0] vp, logic [63:0] vc, logic [63:0] vm,
                                bit c, int rdy, bit de = 0, bit ie = 0, bit iv = 1, bit h = 0);
    instr_t r;
    r.icode = ic; r.valp = vp; r.valc = vc; r.valm = vm; r.cnd = c; r.ready_at = rdy;
    r.derr = de; r.imem_err = ie; r.ivalid = iv; r.hlt = h;
    return r;
  endfunction

  function automatic bit is_mem_icode(logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  // Transaction-level model of one instruction's outcome.
  task automatic model_step(input instr_t in, output int e_cyc, output int e_mreq);
    int k;
    e_mreq = 0;
    e_cyc  = 6;
    if (in.imem_err)    begin m_stat = 3; m_halt = 1; e_cyc = 2; end
    else if (!in.ivalid) begin m_stat = 4; m_halt = 1; e_cyc = 2; end
    else if (in.hlt)     begin m_stat = 2; m_halt = 1; e_cyc = 2; end
    else begin
      if (is_mem_icode(in.icode)) begin
        k = (in.ready_at >= 1 && in.ready_at <= T) ? in.ready_at : T;
        e_mreq = k;
        e_cyc  = 5 + k;
        if (in.ready_at < 1 || in.ready_at > T || in.derr) begin
          m_stat = 3; m_halt = 1; e_cyc = 3 + k;
        end
      end
      if (!m_halt) begin
        if (in.icode == 4'h8 || (in.icode == 4'h7 && in.cnd)) m_pc = in.valc;
        else if (in.icode == 4'h9) m_pc = in.valm;
        else m_pc = in.valp;
        m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  // Acts as fetch/execute/memory for one instruction starting from a FETCH cycle.
  // Returns cycles until the next FETCH or HALTED, cycles with mem_req high, and one-hot status.
  task automatic do_instr(input instr_t in, output int cyc, output int mreq, output bit en_ok);
    int mc = 0;
    int ens;
    bus.icode = in.icode; bus.valP = in.valp; bus.valC = in.valc; bus.valM = in.valm;
    bus.cnd = in.cnd; bus.imem_error = in.imem_err; bus.instr_valid = in.ivalid; bus.hlt = in.hlt;
    cyc = 0; mreq = 0; en_ok = 1;
    for (int i = 0; i < 100; i++) begin
      ens = int'(bus.fetch_en) + int'(bus.decode_en) + int'(bus.execute_en) +
            int'(bus.memory_en) + int'(bus.wb_en);
      if (ens > 1 || (bus.halted && ens != 0)) en_ok = 0;
      if (bus.mem_req) mreq++;
      if (bus.memory_en) begin
        mc++;
        if (is_mem_icode(in.icode)) begin
          bus.mem_ready  = (in.ready_at != 0 && mc >= in.ready_at);
          bus.dmem_error = in.derr;
        end else begin
          bus.mem_ready  = 1'($urandom);
          bus.dmem_error = 1'($urandom);
        end
      end else begin
        bus.mem_ready = 0; bus.dmem_error = 0;
      end
      @(negedge clk);
      cyc++;
      if (bus.fetch_en || bus.halted) break;
    end
    bus.mem_ready = 0; bus.dmem_error = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    bus.start = 0; bus.mem_ready = 0; bus.dmem_error = 0; bus.icode = 0; bus.cnd = 0;
    bus.instr_valid = 1; bus.imem_error = 0; bus.hlt = 0; bus.valP = 0; bus.valC = 0; bus.valM = 0;
    @(negedge clk);
    rst_n = 1;
    m_pc = 64'd0; m_cnt = 32'd0; m_stat = 3'd1; m_halt = 0;
  endtask

  task automatic restart();
    int n = 0;
    apply_reset();
    bus.start = 1;
    @(negedge clk);
    bus.start = 0;
    while (!bus.fetch_en && n < 8) begin @(negedge clk); n++; end
    checks++; if (bus.fetch_en !== 1'b1) begin errors++; $display("FAIL start_to_fetch: fetch_en=%0b want 1", bus.fetch_en); end
    checks++; if (bus.pc !== 64'd0) begin errors++; $display("FAIL start_pc: got %0h want 0", bus.pc); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (bus.pc !== 64'd0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.stat !== 3'd1) begin errors++; $display("FAIL reset_stat: got %0d want 1", bus.stat); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", bus.halted); end
    checks++; if (bus.instr_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.instr_cnt); end
    checks++; if ({bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.wb_en, bus.mem_req} !== 6'b0)
      begin errors++; $display("FAIL reset_enables: got %b want 000000",
        {bus.fetch_en, bus.decode_en, bus.execute_en, bus.memory_en, bus.wb_en, bus.mem_req}); end
    apply_reset();
    bus.mem_ready = 1;
    repeat (3) @(negedge clk);
    checks++; if (bus.fetch_en !== 1'b0) begin errors++; $display("FAIL idle_hold: fetch_en=%0b want 0", bus.fetch_en); end
    bus.mem_ready = 0;
  endtask

  // OPq at 0 then halt at 2; then start must not revive the core.
  task automatic test_opq_halt();
    instr_t t[2];
    int cyc, mreq, e_cyc, e_mreq;
    bit en_ok;
    t[0] = mk(4'h6, 64'd2, 64'd0, 64'd0, 0, 0);
    t[1] = mk(4'h0, 64'd3, 64'd0, 64'd0, 0, 0, 0, 0, 1, 1);
    restart();
    for (int i = 0; i < 2; i++) begin
      do_instr(t[i], cyc, mreq, en_ok);
      model_step(t[i], e_cyc, e_mreq);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL opq_halt[%0d] latency: got %0d want %0d", i, cyc, e_cyc); end
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL opq_halt[%0d] pc: got %0h want %0h", i, bus.pc, m_pc); end
      checks++; if (bus.instr_cnt !== m_cnt) begin errors++; $display("FAIL opq_halt[%0d] cnt: got %0d want %0d", i, bus.instr_cnt, m_cnt); end
      checks++; if (bus.stat !== m_stat) begin errors++; $display("FAIL opq_halt[%0d] stat: got %0d want %0d", i, bus.stat, m_stat); end
      checks++; if (bus.halted !== m_halt) begin errors++; $display("FAIL opq_halt[%0d] halted: got %0b want %0b", i, bus.halted, m_halt); end
    end
    bus.start = 1;
    repeat (3) @(negedge clk);
    bus.start = 0;
    checks++; if (bus.halted !== 1'b1 || bus.fetch_en !== 1'b0) begin errors++; $display("FAIL halt_sticky: halted=%0b fetch_en=%0b want 1/0", bus.halted, bus.fetch_en); end
    checks++; if (bus.stat !== 3'd2) begin errors++; $display("FAIL halt_stat_sticky: got %0d want 2", bus.stat); end
  endtask

  // Memory handshake, control flow and data-memory faults in one directed table.
  task automatic test_directed();
    instr_t t[10];
    int cyc, mreq, e_cyc, e_mreq;
    bit en_ok;
    t[0] = mk(4'h3, 64'd10, 64'h55, 64'd0, 0, 1);                 // irmovq, ready ignored
    t[1] = mk(4'h5, 64'd20, 64'd0, 64'd0, 0, 3);                  // mrmovq, ready on 3rd cycle
    t[2] = mk(4'h7, 64'd29, 64'h100, 64'd0, 1, 0);                // jXX taken
    t[3] = mk(4'h7, 64'h109, 64'h300, 64'd0, 0, 0);               // jXX not taken
    t[4] = mk(4'h8, 64'h112, 64'h200, 64'd0, 0, 1);               // call
    t[5] = mk(4'h9, 64'h201, 64'd0, 64'h40, 0, 2);                // ret -> 0x40
    t[6] = mk(4'hA, 64'h42, 64'd0, 64'd0, 0, T);                  // pushq ready in last allowed cycle
    t[7] = mk(4'hB, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 0, 1); // popq, pc near wrap
    t[8] = mk(4'h6, 64'd0, 64'd0, 64'd0, 0, 0);                   // OPq wraps to 0
    t[9] = mk(4'h4, 64'd10, 64'd0, 64'd0, 0, 0);                  // rmmovq, never ready -> timeout
    restart();
    for (int i = 0; i < 10; i++) begin
      do_instr(t[i], cyc, mreq, en_ok);
      model_step(t[i], e_cyc, e_mreq);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL dir[%0d] latency: got %0d want %0d", i, cyc, e_cyc); end
      checks++; if (mreq !== e_mreq) begin errors++; $display("FAIL dir[%0d] mem_req_cycles: got %0d want %0d", i, mreq, e_mreq); end
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL dir[%0d] pc: got %0h want %0h", i, bus.pc, m_pc); end
      checks++; if (bus.stat !== m_stat) begin errors++; $display("FAIL dir[%0d] stat: got %0d want %0d", i, bus.stat, m_stat); end
      checks++; if (bus.instr_cnt !== m_cnt) begin errors++; $display("FAIL dir[%0d] cnt: got %0d want %0d", i, bus.instr_cnt, m_cnt); end
      checks++; if (bus.halted !== m_halt) begin errors++; $display("FAIL dir[%0d] halted: got %0b want %0b", i, bus.halted, m_halt); end
      checks++; if (en_ok !== 1'b1) begin errors++; $display("FAIL dir[%0d] onehot: got %0b want 1", i, en_ok); end
    end
  endtask

  // Decode and data-memory faults, each from a fresh reset after one good instruction.
  task automatic test_faults();
    instr_t f[4];
    instr_t good;
    int cyc, mreq, e_cyc, e_mreq;
    bit en_ok;
    good = mk(4'h1, 64'd1, 64'd0, 64'd0, 0, 0);
    f[0] = mk(4'hF, 64'd2, 64'd0, 64'd0, 0, 0, 0, 0, 0, 0);  // illegal icode -> INS
    f[1] = mk(4'hF, 64'd2, 64'd0, 64'd0, 0, 0, 0, 1, 0, 1);  // imem error wins -> ADR
    f[2] = mk(4'h0, 64'd2, 64'd0, 64'd0, 0, 0, 0, 0, 0, 1);  // INS beats HLT
    f[3] = mk(4'h5, 64'd11, 64'd0, 64'd0, 0, 2, 1);          // dmem error -> ADR
    for (int i = 0; i < 4; i++) begin
      restart();
      do_instr(good, cyc, mreq, en_ok);
      model_step(good, e_cyc, e_mreq);
      do_instr(f[i], cyc, mreq, en_ok);
      model_step(f[i], e_cyc, e_mreq);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL fault[%0d] latency: got %0d want %0d", i, cyc, e_cyc); end
      checks++; if (bus.stat !== m_stat) begin errors++; $display("FAIL fault[%0d] stat: got %0d want %0d", i, bus.stat, m_stat); end
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL fault[%0d] pc: got %0h want %0h", i, bus.pc, m_pc); end
      checks++; if (bus.instr_cnt !== m_cnt) begin errors++; $display("FAIL fault[%0d] cnt: got %0d want %0d", i, bus.instr_cnt, m_cnt); end
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL fault[%0d] halted: got %0b want 1", i, bus.halted); end
    end
  endtask

  // Asynchronous reset while a memory request is outstanding.
  task automatic test_reset_mid_memory();
    int cyc, mreq, e_cyc, e_mreq, n;
    bit en_ok;
    instr_t a;
    a = mk(4'h3, 64'd10, 64'd0, 64'd0, 0, 0);
    restart();
    do_instr(a, cyc, mreq, en_ok);
    model_step(a, e_cyc, e_mreq);
    bus.icode = 4'h5; bus.valP = 64'd20; bus.mem_ready = 0;
    n = 0;
    while (!bus.memory_en && n < 8) begin @(negedge clk); n++; end
    checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_req_before: got %0b want 1", bus.mem_req); end
    #2 rst_n = 0;
    #1;
    checks++; if (bus.mem_req !== 1'b0 || bus.memory_en !== 1'b0) begin errors++; $display("FAIL mid_mem_async_drop: mem_req=%0b memory_en=%0b want 0/0", bus.mem_req, bus.memory_en); end
    checks++; if (bus.pc !== 64'd0) begin errors++; $display("FAIL mid_mem_pc: got %0h want 0", bus.pc); end
    checks++; if (bus.instr_cnt !== 32'd0 || bus.stat !== 3'd1 || bus.halted !== 1'b0) begin errors++;
      $display("FAIL mid_mem_state: cnt=%0d stat=%0d halted=%0b want 0/1/0", bus.instr_cnt, bus.stat, bus.halted); end
    bus.mem_ready = 1;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++; if (bus.fetch_en !== 1'b0 || bus.mem_req !== 1'b0 || bus.stat !== 3'd1) begin errors++;
      $display("FAIL late_ready_idle: fetch_en=%0b mem_req=%0b stat=%0d want 0/0/1", bus.fetch_en, bus.mem_req, bus.stat); end
    bus.mem_ready = 0;
  endtask

  // Random instruction streams; a halt restarts from reset.
  task automatic test_random();
    instr_t r;
    int cyc, mreq, e_cyc, e_mreq;
    bit en_ok;
    restart();
    for (int i = 0; i < 80; i++) begin
      r = mk(4'($urandom_range(1, 11)), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, T)),
             $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, 1, 0);
      if ($urandom_range(0, 39) == 0) begin r.icode = 4'($urandom_range(12, 15)); r.ivalid = 0; end
      if ($urandom_range(0, 39) == 0) begin r.icode = 4'h0; r.hlt = 1; end
      do_instr(r, cyc, mreq, en_ok);
      model_step(r, e_cyc, e_mreq);
      checks++; if (cyc !== e_cyc) begin errors++; $display("FAIL rnd[%0d] icode %0h latency: got %0d want %0d", i, r.icode, cyc, e_cyc); end
      checks++; if (mreq !== e_mreq) begin errors++; $display("FAIL rnd[%0d] mem_req_cycles: got %0d want %0d", i, mreq, e_mreq); end
      checks++; if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd[%0d] pc: got %0h want %0h", i, bus.pc, m_pc); end
      checks++; if (bus.stat !== m_stat) begin errors++; $display("FAIL rnd[%0d] stat: got %0d want %0d", i, bus.stat, m_stat); end
      checks++; if (bus.instr_cnt !== m_cnt) begin errors++; $display("FAIL rnd[%0d] cnt: got %0d want %0d", i, bus.instr_cnt, m_cnt); end
      checks++; if (en_ok !== 1'b1) begin errors++; $display("FAIL rnd[%0d] onehot: got %0b want 1", i, en_ok); end
      if (m_halt) restart();
    end
  endtask

  initial begin
    bus.start = 0; bus.mem_ready = 0; bus.dmem_error = 0; bus.icode = 0; bus.cnd = 0;
    bus.instr_valid = 1; bus.imem_error = 0; bus.hlt = 0; bus.valP = 0; bus.valC = 0; bus.valM = 0;
    test_reset();
    test_opq_halt();
    test_directed();
    test_faults();
    test_reset_mid_memory();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
